fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_pkg.sv | 15 +
 rtl/fifo_stream_reader.sv | 69 ++++++
 tb/tb_fifo_stream_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared sizing for the FIFO-to-stream reader: word width default, skid depth, counter width.
// Pointers step over the three buffer slots and wrap from the last slot back to 0.
package fifo_stream_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int BUF_DEPTH  = 3;
  localparam int CNT_W      = 16;

  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream via a 3-entry buffer.
// Read-to-valid latency is 2 cycles; reads stall when buffer plus in-flight word would exceed 3.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              idle,
  output logic [CNT_W-1:0]  xfer_count
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic [2:0]        fill;
  logic              push;
  logic              pop;

  // Reserve a slot for every outstanding read so the buffer can never overflow,
  // independent of what the downstream does this cycle.
  assign fill       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = ~rst & ~fifo_empty & (fill < 3'(BUF_DEPTH));

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign idle    = ~m_valid & ~inflight;

  assign push = inflight;
  assign pop  = m_valid & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      xfer_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        mem[wr_ptr] <= fifo_rdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        xfer_count <= xfer_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench: queue-based upstream FIFO model, scoreboard fed at push time and
// drained by an independent monitor; directed phases cover latency, stalls, reset and counter wrap.
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          idle;
  logic [15:0]   xfer_count;

  fifo_stream_reader #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .idle       (idle),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [DW-1:0] q[$];      // upstream FIFO contents
  logic [DW-1:0] pend[$];   // words written this cycle, visible to the FIFO next edge
  logic [DW-1:0] exp_q[$];  // scoreboard: expected downstream order

  int            rd_total   = 0;
  int            pop_total  = 0;
  logic          hs_prev    = 1'b0;
  logic          rd_prev    = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_dat  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    pend.push_back(d);
    exp_q.push_back(d);
  endtask

  // Upstream FIFO: registered read data, 1-cycle latency, up to 32 words.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) fifo_rdata <= q.pop_front();
    while (pend.size() > 0) q.push_back(pend.pop_front());
    fifo_empty <= (q.size() == 0);
  end

  // Monitor: scoreboard compare on handshakes plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      rd_total   = 0;
      pop_total  = 0;
      hs_prev    = 1'b0;
      rd_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (hs_prev) pop_total++;
      if (rd_prev) rd_total++;
      chk("xfer_count_track", {16'h0, xfer_count}, pop_total & 32'hFFFF);
      chk("occ_plus_inflight_le3", 32'(rd_total - pop_total <= 3), 32'd1);
      chk("rd_en_while_empty", {31'h0, fifo_rd_en & fifo_empty}, 32'd0);
      if (stall_prev) begin
        chk("stall_valid_held", {31'h0, m_valid}, 32'd1);
        chk("stall_data_held", {24'h0, m_data}, {24'h0, stall_dat});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: actual=%0h required=none", m_data);
        end else begin
          chk("stream_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
        end
      end
      hs_prev    = m_valid & m_ready;
      rd_prev    = fifo_rd_en;
      stall_prev = m_valid & ~m_ready;
      stall_dat  = m_data;
    end
  end

  task automatic observe(input int n, output int rd_n, output int rd_first,
                         output int v_n, output int v_first, output int v_last);
    rd_n = 0; rd_first = -1; v_n = 0; v_first = -1; v_last = -1;
    repeat (n) begin
      @(negedge clk); #1;
      if (fifo_rd_en) begin
        if (rd_first < 0) rd_first = cyc;
        rd_n++;
      end
      if (m_valid) begin
        if (v_first < 0) v_first = cyc;
        v_last = cyc;
        v_n++;
      end
    end
  endtask

  initial begin
    int rd_n, rd_first, v_n, v_first, v_last;
    int sent, guard, pushed;
    bit found, done;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rd_en", {31'h0, fifo_rd_en}, 32'd0);
    chk("reset_m_valid", {31'h0, m_valid}, 32'd0);
    chk("reset_m_data", {24'h0, m_data}, 32'd0);
    chk("reset_idle", {31'h0, idle}, 32'd1);
    chk("reset_xfer_count", {16'h0, xfer_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word: 2-cycle read-to-valid latency
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_word(8'hA5);
    observe(10, rd_n, rd_first, v_n, v_first, v_last);
    chk("single_rd_count", rd_n, 1);
    chk("single_valid_cycles", v_n, 1);
    chk("single_latency", v_first - rd_first, 2);
    chk("single_xfer_count", {16'h0, xfer_count}, 32'd1);
    chk("single_idle", {31'h0, idle}, 32'd1);

    // Streaming 32 words at full rate
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) push_word(8'(i));
    observe(45, rd_n, rd_first, v_n, v_first, v_last);
    chk("stream_rd_count", rd_n, 32);
    chk("stream_valid_cycles", v_n, 32);
    chk("stream_contiguous", v_last - v_first + 1, 32);
    chk("stream_xfer_count", {16'h0, xfer_count}, 32'd33);
    chk("stream_idle", {31'h0, idle}, 32'd1);

    // Backpressure: buffer fills to 3 and holds the head word
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    observe(10, rd_n, rd_first, v_n, v_first, v_last);
    chk("bp_rd_count", rd_n, 3);
    chk("bp_m_valid", {31'h0, m_valid}, 32'd1);
    chk("bp_m_data_head", {24'h0, m_data}, 32'h10);
    @(posedge clk); #1;
    m_ready = 1'b1;
    observe(20, rd_n, rd_first, v_n, v_first, v_last);
    chk("bp_drain_rd_count", rd_n, 5);
    chk("bp_drain_valid_cycles", v_n, 8);
    chk("bp_drain_contiguous", v_last - v_first + 1, 8);
    chk("bp_xfer_count", {16'h0, xfer_count}, 32'd41);

    // Random traffic with 50% downstream ready
    @(posedge clk); #1;
    sent = 0;
    guard = 0;
    while ((sent < 1000 || exp_q.size() > 0) && guard < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && q.size() + pend.size() < 32 && $urandom_range(0, 3) != 0) begin
        push_word(8'($urandom));
        sent++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("random_within_budget", 32'(guard < 20000), 32'd1);
    chk("random_drained", exp_q.size(), 0);

    // Reset while two words are buffered and one is in flight
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'hC0 + i));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (rd_total - pop_total == 3) found = 1'b1;
    end
    chk("midreset_setup_reached", {31'h0, found}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_m_valid", {31'h0, m_valid}, 32'd0);
    chk("midreset_xfer_count", {16'h0, xfer_count}, 32'd0);
    chk("midreset_idle", {31'h0, idle}, 32'd1);
    chk("midreset_rd_en", {31'h0, fifo_rd_en}, 32'd0);
    chk("midreset_m_data", {24'h0, m_data}, 32'd0);
    q.delete();
    pend.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    m_ready = 1'b1;
    observe(10, rd_n, rd_first, v_n, v_first, v_last);
    chk("postreset_valid_cycles", v_n, 0);
    chk("postreset_rd_count", rd_n, 0);
    chk("postreset_idle", {31'h0, idle}, 32'd1);

    // Counter wrap: 65536 pops bring xfer_count back to 0
    @(posedge clk); #1;
    m_ready = 1'b1;
    pushed = 0;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 70000) begin
      if (pushed < 65536 && q.size() + pend.size() < 32) begin
        push_word(8'(pushed));
        pushed++;
      end
      @(negedge clk); #1;
      if (pop_total == 65535) chk("wrap_ffff", {16'h0, xfer_count}, 32'hFFFF);
      if (pop_total == 65536) begin
        chk("wrap_zero", {16'h0, xfer_count}, 32'h0);
        done = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("wrap_reached", {31'h0, done}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("final_no_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
